mem_burst_ctrl: RTL and testbench
=================================

# mem_burst_ctrl

Parametrised successor of the byte-wide RAM interface controller. It arbitrates instruction-line fetches, loads and stores onto a single byte-wide synchronous RAM port. Reads are pipelined: one address is issued per cycle, and data is captured `READ_LAT` cycles later. The block sits between the Fetcher/LoadStoreBuffer and `ram.v`.

## Interface
Parameters:
- `ADDR_W`, 32: address width.
- `LINE_BYTES`, 4: bytes per fetch burst; power of two, 4..16.
- `READ_LAT`, 1: cycles from RAM address to RAM read data; 1..3.

Ports:
- `clk` in 1: single clock.
- `rst` in 1: synchronous, active-high reset.
- `io_buffer_full` in 1: UART output buffer full.
- `ram_data_in` in 8: RAM read byte.
- `ram_data_out` out 8: RAM write byte.
- `ram_address_out` out `ADDR_W`: RAM byte address.
- `ram_rw_signal_out` out 1: 1 = write, 0 = read.
- `rob_rollback_in` in 1: flush speculative traffic.
- `fet_request_in` in 1 / `fet_address_in` in `ADDR_W`: line fetch request; the address is `LINE_BYTES`-aligned.
- `fet_ready_out` out 1 / `fet_line_out` out `8*LINE_BYTES`: line returned, byte 0 in the LSBs.
- `lsb_request_in` in 1, `lsb_rw_signal_in` in 1 (1 = store), `lsb_address_in` in `ADDR_W`, `lsb_goal_in` in 3 (1/2/4 bytes), `lsb_data_in` in 32.
- `lsb_ready_out` out 1 / `lsb_data_out` out 32: load data is zero-extended and little-endian.
- `busy_out` out 1: transaction in progress.

## Operation
- Each source has a one-deep pending slot: fetch, load, store. A request pulse writes its slot; a new request to an occupied slot overwrites it.
- States: IDLE → ISSUE → (DRAIN for reads) → IDLE.
- IDLE arbitration order: store (if issuable) > load > fetch. Selecting a request clears its slot.
- ISSUE:
  - Drive address `base+k` for k = 0..n-1, one per cycle.
  - Writes drive `ram_rw_signal_out`=1 and byte k of the data.
  - Reads tag each address in a `READ_LAT`-deep valid/index shift pipe. The returning byte is written to `buffer[8*idx +: 8]`.
- DRAIN: entered after the last read address; waits until the pipe is empty.
- Completion:
  - One-cycle ready pulse. For loads and fetches, the data output is updated on the same edge.
  - Return to IDLE on the same edge.
- Whenever no address is being issued: `ram_address_out`=0 and `ram_rw_signal_out`=0.
- Rollback:
  - Clears the fetch and load slots.
  - Aborts an in-flight load or fetch to IDLE and clears the read pipe, so late bytes are discarded.
  - Never cancels a store, whether pending or in flight.
  - A store request arriving in the rollback cycle is still captured.
  - No ready pulse is produced for aborted work.
- Outputs at reset: all ready outputs 0, data outputs 0, `ram_address_out` 0, `ram_rw_signal_out` 0, `ram_data_out` 0, `busy_out` 0. All slots cleared; state IDLE.

## Timing
- Request sampled at edge E0; it wins arbitration at E1 and the byte 0 address is driven after E1 (if IDLE).
- Read of n bytes: ready pulse after edge E0+n+`READ_LAT`.
  - Example: a 4-byte load with `READ_LAT`=1 readies after E5.
- Write of n bytes: bytes written after E1..En; ready pulse after E(n+1).
- Back-to-back: the next transaction issues at the edge after the ready edge, so there is one idle RAM cycle between transactions.
- The fetch and load slots accept new requests while a transaction is busy.

## Configuration
- `MEM_IO_STALL_EN` defined: a pending store with `addr[17:16]==2'b11` is not issuable while `io_buffer_full`=1. Loads and fetches may bypass it.
- `MEM_IO_STALL_EN` undefined: `io_buffer_full` is ignored and stores are always issuable.

## Structure
- Shared package/header holds:
  - the state encoding (IDLE/ISSUE/DRAIN);
  - the source encoding (NONE/FETCH/LOAD/STORE);
  - `RAM_DATA_LEN`=8;
  - the IO region constant `2'b11` at bits [17:16];
  - `READ`/`WRITE`.
- Sub-module `mem_read_pipe`: parametrised `READ_LAT`-deep shift register of {valid, byte index} with a synchronous flush input.

## Test plan
- Reset then fetch at 0x100, RAM bytes 13,00,00,00, `READ_LAT`=1: `fet_line_out`=0x00000013 pulsed after E5; no other ready.
- Same cycle: store 4B 0xDEADBEEF to 0x40, load 1B from 0x40, fetch at 0x0: store completes first, then load returns 0xEF, then fetch ready.
- Load 4B from 0x200, rollback at E3: no `lsb_ready_out`; RAM lines idle (address 0, read) from E4; a subsequent load returns correct data.
- Store 1B 0x41 to 0x30000 with `io_buffer_full`=1 for 10 cycles, `MEM_IO_STALL_EN` defined: first write cycle is the edge after full drops. With the macro undefined, the write occurs after E1.
- `LINE_BYTES`=16, `READ_LAT`=3, fetch at 0x80: 16 consecutive addresses 0x80..0x8F; ready after E19; line matches RAM contents.
- Rollback during an in-flight store: all bytes still written and `lsb_ready_out` still pulsed.

Source files
------------

// File: rtl/mem_burst_ctrl_pkg.sv
// Shared encodings and constants for the byte-wide RAM burst controller.
package mem_burst_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_DRAIN
    } state_e;

    typedef enum logic [1:0] {
        SRC_NONE,
        SRC_FETCH,
        SRC_LOAD,
        SRC_STORE
    } src_e;

    localparam int         RAM_DATA_LEN = 8;
    localparam logic [1:0] IO_REGION    = 2'b11;
    localparam int         IO_REGION_HI = 17;
    localparam int         IO_REGION_LO = 16;
    localparam logic       READ         = 1'b0;
    localparam logic       WRITE        = 1'b1;

    function automatic logic [RAM_DATA_LEN-1:0] word_byte(input logic [31:0] w,
                                                          input logic [1:0]  k);
        logic [RAM_DATA_LEN-1:0] b;
        case (k)
            2'd0:    b = w[7:0];
            2'd1:    b = w[15:8];
            2'd2:    b = w[23:16];
            default: b = w[31:24];
        endcase
        return b;
    endfunction

endpackage

// File: rtl/mem_burst_ctrl_read_pipe.sv
// READ_LAT-deep {valid, byte index} shift register tracking outstanding RAM reads.
module mem_read_pipe #(
    parameter int READ_LAT = 1,
    parameter int IDX_W    = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush_i,
    input  logic             vld_i,
    input  logic [IDX_W-1:0] idx_i,
    output logic             vld_o,
    output logic [IDX_W-1:0] idx_o
);

    logic [READ_LAT-1:0] vld_q;
    logic [IDX_W-1:0]    idx_q [READ_LAT];

    always_ff @(posedge clk) begin
        if (rst || flush_i) begin
            vld_q <= '0;
        end else begin
            vld_q[0] <= vld_i;
            for (int i = 1; i < READ_LAT; i++) begin
                vld_q[i] <= vld_q[i-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        idx_q[0] <= idx_i;
        for (int i = 1; i < READ_LAT; i++) begin
            idx_q[i] <= idx_q[i-1];
        end
    end

    assign vld_o = vld_q[READ_LAT-1];
    assign idx_o = idx_q[READ_LAT-1];

endmodule

// File: rtl/mem_burst_ctrl.sv
// Arbitrates line fetches, loads and stores onto one byte-wide synchronous RAM port.
// Define MEM_IO_STALL_EN to hold IO-region stores while the UART buffer is full.
module mem_burst_ctrl
    import mem_burst_ctrl_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter int LINE_BYTES = 4,
    parameter int READ_LAT   = 1
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             io_buffer_full,
    input  logic [RAM_DATA_LEN-1:0]          ram_data_in,
    output logic [RAM_DATA_LEN-1:0]          ram_data_out,
    output logic [ADDR_W-1:0]                ram_address_out,
    output logic                             ram_rw_signal_out,
    input  logic                             rob_rollback_in,
    input  logic                             fet_request_in,
    input  logic [ADDR_W-1:0]                fet_address_in,
    output logic                             fet_ready_out,
    output logic [RAM_DATA_LEN*LINE_BYTES-1:0] fet_line_out,
    input  logic                             lsb_request_in,
    input  logic                             lsb_rw_signal_in,
    input  logic [ADDR_W-1:0]                lsb_address_in,
    input  logic [2:0]                       lsb_goal_in,
    input  logic [31:0]                      lsb_data_in,
    output logic                             lsb_ready_out,
    output logic [31:0]                      lsb_data_out,
    output logic                             busy_out
);

    localparam int IDX_W  = $clog2(LINE_BYTES);
    localparam int LINE_W = RAM_DATA_LEN * LINE_BYTES;

    state_e              state_q, state_d;
    src_e                src_q, src_d;
    logic [ADDR_W-1:0]   base_q, base_d;
    logic [IDX_W-1:0]    cnt_q, cnt_d, last_q, last_d;
    logic [31:0]         sdata_q, sdata_d;
    logic [LINE_W-1:0]   rbuf_q, rbuf_d;
    logic                fet_rdy_q, fet_rdy_d, lsb_rdy_q, lsb_rdy_d;
    logic [LINE_W-1:0]   fet_line_q, fet_line_d;
    logic [31:0]         lsb_data_q, lsb_data_d;

    logic                fv_q, fv_d, lv_q, lv_d, sv_q, sv_d;
    logic [ADDR_W-1:0]   fa_q, fa_d, la_q, la_d, sa_q, sa_d;
    logic [IDX_W-1:0]    lg_q, lg_d, sl_q, sl_d;
    logic [31:0]         sd_q, sd_d;

    logic                push_vld, flush, pv, rd_done, store_ok, reading, abort, issuing;
    logic [IDX_W-1:0]    push_idx, pidx;

    mem_read_pipe #(
        .READ_LAT (READ_LAT),
        .IDX_W    (IDX_W)
    ) u_read_pipe (
        .clk     (clk),
        .rst     (rst),
        .flush_i (flush),
        .vld_i   (push_vld),
        .idx_i   (push_idx),
        .vld_o   (pv),
        .idx_o   (pidx)
    );

`ifdef MEM_IO_STALL_EN
    assign store_ok = sv_q && !(io_buffer_full &&
                                (sa_q[IO_REGION_HI:IO_REGION_LO] == IO_REGION));
`else
    logic unused_io_full;
    assign unused_io_full = io_buffer_full;
    assign store_ok       = sv_q;
`endif

    assign reading = (src_q == SRC_FETCH) || (src_q == SRC_LOAD);
    assign abort   = rob_rollback_in && reading && (state_q != ST_IDLE);
    assign issuing = (state_q == ST_ISSUE);

    always_comb begin
        state_d    = state_q;
        src_d      = src_q;
        base_d     = base_q;
        cnt_d      = cnt_q;
        last_d     = last_q;
        sdata_d    = sdata_q;
        rbuf_d     = rbuf_q;
        fet_rdy_d  = 1'b0;
        lsb_rdy_d  = 1'b0;
        fet_line_d = fet_line_q;
        lsb_data_d = lsb_data_q;
        fv_d = fv_q; fa_d = fa_q;
        lv_d = lv_q; la_d = la_q; lg_d = lg_q;
        sv_d = sv_q; sa_d = sa_q; sl_d = sl_q; sd_d = sd_q;
        push_vld = 1'b0;
        push_idx = '0;
        flush    = 1'b0;
        rd_done  = 1'b0;

        for (int b = 0; b < LINE_BYTES; b++) begin
            if (pv && (pidx == IDX_W'(b))) rbuf_d[RAM_DATA_LEN*b +: RAM_DATA_LEN] = ram_data_in;
        end

        unique case (state_q)
            ST_IDLE: begin
                if (store_ok) begin
                    src_d = SRC_STORE; base_d = sa_q; last_d = sl_q; sdata_d = sd_q;
                    sv_d = 1'b0; cnt_d = '0; state_d = ST_ISSUE;
                end else if (lv_q && !rob_rollback_in) begin
                    src_d = SRC_LOAD; base_d = la_q; last_d = lg_q;
                    lv_d = 1'b0; cnt_d = '0; rbuf_d = '0; push_vld = 1'b1; state_d = ST_ISSUE;
                end else if (fv_q && !rob_rollback_in) begin
                    src_d = SRC_FETCH; base_d = fa_q; last_d = IDX_W'(LINE_BYTES - 1);
                    fv_d = 1'b0; cnt_d = '0; rbuf_d = '0; push_vld = 1'b1; state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (abort) begin
                    state_d = ST_IDLE; src_d = SRC_NONE; flush = 1'b1;
                end else if (cnt_q != last_q) begin
                    cnt_d    = cnt_q + 1'b1;
                    push_vld = reading;
                    push_idx = cnt_q + 1'b1;
                end else if (src_q == SRC_STORE) begin
                    lsb_rdy_d = 1'b1; state_d = ST_IDLE; src_d = SRC_NONE;
                end else if (pv && (pidx == last_q)) begin
                    rd_done = 1'b1;
                end else begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (abort) begin
                    state_d = ST_IDLE; src_d = SRC_NONE; flush = 1'b1;
                end else if (pv && (pidx == last_q)) begin
                    rd_done = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // The last byte lands in rbuf_d on this edge, so publish from rbuf_d.
        if (rd_done) begin
            state_d = ST_IDLE;
            src_d   = SRC_NONE;
            if (src_q == SRC_FETCH) begin
                fet_line_d = rbuf_d; fet_rdy_d = 1'b1;
            end else begin
                lsb_data_d = rbuf_d[31:0]; lsb_rdy_d = 1'b1;
            end
        end

        if (fet_request_in) begin
            fv_d = 1'b1; fa_d = fet_address_in;
        end
        if (lsb_request_in) begin
            if (lsb_rw_signal_in == WRITE) begin
                sv_d = 1'b1; sa_d = lsb_address_in;
                sl_d = IDX_W'(lsb_goal_in - 3'd1); sd_d = lsb_data_in;
            end else begin
                lv_d = 1'b1; la_d = lsb_address_in;
                lg_d = IDX_W'(lsb_goal_in - 3'd1);
            end
        end
        if (rob_rollback_in) begin
            fv_d = 1'b0; lv_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            src_q      <= SRC_NONE;
            fv_q       <= 1'b0;
            lv_q       <= 1'b0;
            sv_q       <= 1'b0;
            fet_rdy_q  <= 1'b0;
            lsb_rdy_q  <= 1'b0;
            fet_line_q <= '0;
            lsb_data_q <= '0;
        end else begin
            state_q    <= state_d;
            src_q      <= src_d;
            fv_q       <= fv_d;
            lv_q       <= lv_d;
            sv_q       <= sv_d;
            fet_rdy_q  <= fet_rdy_d;
            lsb_rdy_q  <= lsb_rdy_d;
            fet_line_q <= fet_line_d;
            lsb_data_q <= lsb_data_d;
        end
    end

    always_ff @(posedge clk) begin
        base_q  <= base_d;
        cnt_q   <= cnt_d;
        last_q  <= last_d;
        sdata_q <= sdata_d;
        rbuf_q  <= rbuf_d;
        fa_q    <= fa_d;
        la_q    <= la_d;
        lg_q    <= lg_d;
        sa_q    <= sa_d;
        sl_q    <= sl_d;
        sd_q    <= sd_d;
    end

    assign ram_address_out   = issuing ? (base_q + ADDR_W'(cnt_q)) : '0;
    assign ram_rw_signal_out = (issuing && (src_q == SRC_STORE)) ? WRITE : READ;
    assign ram_data_out      = (issuing && (src_q == SRC_STORE)) ? word_byte(sdata_q, cnt_q[1:0]) : '0;
    assign fet_ready_out     = fet_rdy_q;
    assign fet_line_out      = fet_line_q;
    assign lsb_ready_out     = lsb_rdy_q;
    assign lsb_data_out      = lsb_data_q;
    assign busy_out          = (state_q != ST_IDLE);

endmodule

// File: tb/tb_mem_burst_ctrl.sv
// Directed bench for mem_burst_ctrl: default build plus a 16-byte, 3-latency instance.
module tb_mem_burst_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int n_vec  = 0;
    int n_miss = 0;

    // Instance A: default parameters
    logic        a_full = 0, a_rb = 0, a_fet_req = 0, a_lsb_req = 0, a_lsb_rw = 0;
    logic [31:0] a_fet_addr = 0, a_lsb_addr = 0, a_lsb_wdata = 0;
    logic [2:0]  a_goal = 0;
    logic [7:0]  a_ram_in = 0, a_wdata;
    logic [31:0] a_addr, a_line, a_ldata;
    logic        a_rw, a_frdy, a_lrdy, a_busy;

    // Instance B: 16-byte lines, read latency 3
    logic         b_fet_req = 0;
    logic [31:0]  b_fet_addr = 0;
    logic [7:0]   b_ram_in = 0, b_wdata;
    logic [31:0]  b_addr, b_ldata, b_a1 = 0, b_a2 = 0;
    logic [127:0] b_line;
    logic         b_rw, b_frdy, b_lrdy, b_busy;

    mem_burst_ctrl u_dut (
        .clk(clk), .rst(rst), .io_buffer_full(a_full),
        .ram_data_in(a_ram_in), .ram_data_out(a_wdata), .ram_address_out(a_addr),
        .ram_rw_signal_out(a_rw), .rob_rollback_in(a_rb),
        .fet_request_in(a_fet_req), .fet_address_in(a_fet_addr),
        .fet_ready_out(a_frdy), .fet_line_out(a_line),
        .lsb_request_in(a_lsb_req), .lsb_rw_signal_in(a_lsb_rw),
        .lsb_address_in(a_lsb_addr), .lsb_goal_in(a_goal), .lsb_data_in(a_lsb_wdata),
        .lsb_ready_out(a_lrdy), .lsb_data_out(a_ldata), .busy_out(a_busy)
    );

    mem_burst_ctrl #(.ADDR_W(32), .LINE_BYTES(16), .READ_LAT(3)) u_dut16 (
        .clk(clk), .rst(rst), .io_buffer_full(1'b0),
        .ram_data_in(b_ram_in), .ram_data_out(b_wdata), .ram_address_out(b_addr),
        .ram_rw_signal_out(b_rw), .rob_rollback_in(1'b0),
        .fet_request_in(b_fet_req), .fet_address_in(b_fet_addr),
        .fet_ready_out(b_frdy), .fet_line_out(b_line),
        .lsb_request_in(1'b0), .lsb_rw_signal_in(1'b0),
        .lsb_address_in(32'h0), .lsb_goal_in(3'd0), .lsb_data_in(32'h0),
        .lsb_ready_out(b_lrdy), .lsb_data_out(b_ldata), .busy_out(b_busy)
    );

    // RAM model: preset contents overlaid by bytes written through instance A.
    logic [4095:0] wval;
    logic [7:0]    wmem [0:4095];

    function automatic logic [11:0] mem_idx(input logic [31:0] a);
        return {a[17:16], a[9:0]};
    endfunction

    function automatic logic [7:0] init_byte(input logic [31:0] a);
        if (a[31:4] == 28'h8) return {4'hA, a[3:0]};
        case (a)
            32'h100: return 8'h13;
            32'h000: return 8'h11;
            32'h001: return 8'h22;
            32'h002: return 8'h33;
            32'h003: return 8'h44;
            32'h200: return 8'h01;
            32'h201: return 8'h02;
            32'h202: return 8'h03;
            32'h203: return 8'h04;
            default: return 8'h00;
        endcase
    endfunction

    function automatic logic [7:0] mem_rd(input logic [31:0] a);
        return wval[mem_idx(a)] ? wmem[mem_idx(a)] : init_byte(a);
    endfunction

    always @(posedge clk) begin
        if (rst) wval <= '0;
        else if (a_rw) begin
            wval[mem_idx(a_addr)] <= 1'b1;
            wmem[mem_idx(a_addr)] <= a_wdata;
        end
        b_a1 <= b_addr;
        b_a2 <= b_a1;
    end

    // Read data for the address issued READ_LAT-1 cycles earlier, ready before the capture edge.
    always @(negedge clk) begin
        a_ram_in <= mem_rd(a_addr);
        b_ram_in <= mem_rd(b_a2);
    end

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [31:0] w;
    int          wr_edge;

    initial begin
        tick(); tick();
        chk("rst_addr",  a_addr,  0);
        chk("rst_rw",    a_rw,    0);
        chk("rst_wdata", a_wdata, 0);
        chk("rst_frdy",  a_frdy,  0);
        chk("rst_lrdy",  a_lrdy,  0);
        chk("rst_line",  a_line,  0);
        chk("rst_ldata", a_ldata, 0);
        chk("rst_busy",  a_busy,  0);
        chk("rst_bline", b_line,  0);
        rst = 1'b0;
        tick();

        // Fetch of 0x100
        a_fet_req = 1; a_fet_addr = 32'h100;
        tick();
        a_fet_req = 0;
        for (int e = 1; e <= 6; e++) begin
            tick();
            chk("t1_frdy", a_frdy, e == 5);
            chk("t1_lrdy", a_lrdy, 0);
            if (e <= 4) chk("t1_addr", a_addr, 32'h100 + e - 1);
            if (e == 5) chk("t1_line", a_line, 32'h0000_0013);
        end

        // Store + fetch together, load one cycle later: store, then load, then fetch
        w = 32'hDEAD_BEEF;
        a_lsb_req = 1; a_lsb_rw = 1; a_lsb_addr = 32'h40; a_goal = 3'd4; a_lsb_wdata = w;
        a_fet_req = 1; a_fet_addr = 32'h0;
        tick();
        a_fet_req = 0; a_lsb_rw = 0; a_goal = 3'd1; a_lsb_wdata = 32'h5555_5555;
        for (int e = 1; e <= 13; e++) begin
            tick();
            if (e == 1) a_lsb_req = 0;
            chk("t2_rw",   a_rw,   (e >= 1 && e <= 4));
            chk("t2_lrdy", a_lrdy, (e == 5 || e == 7));
            chk("t2_frdy", a_frdy, e == 12);
            if (e <= 4) chk("t2_wbyte", a_wdata, w[8*(e-1) +: 8]);
            if (e == 5) chk("t2_idle_busy", a_busy, 0);
            if (e == 6) chk("t2_ld_addr", a_addr, 32'h40);
            if (e == 7) chk("t2_ldata", a_ldata, 32'h0000_00EF);
            if (e == 8) chk("t2_f_addr", a_addr, 32'h0);
            if (e == 12) chk("t2_line", a_line, 32'h4433_2211);
        end

        // Load aborted by rollback sampled at E3, then a clean reload
        a_lsb_req = 1; a_lsb_rw = 0; a_lsb_addr = 32'h200; a_goal = 3'd4;
        tick();
        a_lsb_req = 0;
        for (int e = 1; e <= 8; e++) begin
            tick();
            chk("t3_lrdy", a_lrdy, 0);
            if (e >= 4) begin
                chk("t3_addr", a_addr, 0);
                chk("t3_rw",   a_rw,   0);
                chk("t3_busy", a_busy, 0);
            end
            if (e == 2) a_rb = 1;
            if (e == 3) a_rb = 0;
        end
        a_lsb_req = 1;
        tick();
        a_lsb_req = 0;
        for (int e = 1; e <= 6; e++) begin
            tick();
            chk("t3b_lrdy", a_lrdy, e == 5);
            if (e == 5) chk("t3b_ldata", a_ldata, 32'h0403_0201);
        end

        // IO-region store while the UART buffer is full for 10 sampled edges
`ifdef MEM_IO_STALL_EN
        wr_edge = 10;
`else
        wr_edge = 1;
`endif
        a_full = 1;
        a_lsb_req = 1; a_lsb_rw = 1; a_lsb_addr = 32'h0003_0000; a_goal = 3'd1; a_lsb_wdata = 32'h41;
        tick();
        a_lsb_req = 0;
        for (int e = 1; e <= 13; e++) begin
            tick();
            chk("t4_rw",   a_rw,   e == wr_edge);
            chk("t4_lrdy", a_lrdy, e == wr_edge + 1);
            if (e == wr_edge) begin
                chk("t4_addr",  a_addr,  32'h0003_0000);
                chk("t4_wbyte", a_wdata, 8'h41);
            end
            if (e == 9) a_full = 0;
        end

        // Rollback during an in-flight store must not disturb it
        w = 32'hCAFE_F00D;
        a_lsb_req = 1; a_lsb_rw = 1; a_lsb_addr = 32'h300; a_goal = 3'd4; a_lsb_wdata = w;
        tick();
        a_lsb_req = 0;
        for (int e = 1; e <= 6; e++) begin
            tick();
            chk("t6_rw",   a_rw,   (e >= 1 && e <= 4));
            chk("t6_lrdy", a_lrdy, e == 5);
            if (e <= 4) begin
                chk("t6_wbyte", a_wdata, w[8*(e-1) +: 8]);
                chk("t6_addr",  a_addr,  32'h300 + e - 1);
            end
            if (e == 1) a_rb = 1;
            if (e == 3) a_rb = 0;
        end
        a_lsb_req = 1; a_lsb_rw = 0; a_lsb_addr = 32'h300; a_goal = 3'd4;
        tick();
        a_lsb_req = 0;
        for (int e = 1; e <= 6; e++) begin
            tick();
            chk("t6b_lrdy", a_lrdy, e == 5);
            if (e == 5) chk("t6b_ldata", a_ldata, 32'hCAFE_F00D);
        end

        // 16-byte line, read latency 3
        b_fet_req = 1; b_fet_addr = 32'h80;
        tick();
        b_fet_req = 0;
        for (int e = 1; e <= 21; e++) begin
            tick();
            chk("t5_frdy", b_frdy, e == 19);
            if (e <= 16) chk("t5_addr", b_addr, 32'h80 + e - 1);
            if (e == 17) chk("t5_drain_addr", b_addr, 0);
            if (e == 19) chk("t5_line", b_line, 128'hAFAEADACABAAA9A8_A7A6A5A4A3A2A1A0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
